// File: rtl/cdr_os_dpll.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdr_os_dpll : oversampling CDR with bang-bang phase loop and lock FSM      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cdr_os_dpll #(
  parameter int CNT_W      = 8,
  parameter int OSR_FS     = 8,
  parameter int OSR_HS     = 4,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int IDLE_BITS  = 16
) (
  input  logic             i_clk_ref,
  input  logic             i_rst_n,
  input  logic             i_data,
  input  logic             i_hs_mode,
  input  logic             i_enable,
  output logic             o_recovered_clk,
  output logic             o_data,
  output logic             o_data_valid,
  output logic             o_lock_detect,
  output logic             o_lock_lost,
  output logic [CNT_W-1:0] o_phase_err,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
  localparam logic [CNT_W:0]   c_two        = (CNT_W+1)'(2);
  localparam logic [CNT_W-1:0] c_osr_fs     = CNT_W'(OSR_FS);
  localparam logic [CNT_W-1:0] c_osr_hs     = CNT_W'(OSR_HS);
  localparam logic [CNT_W-1:0] c_tol        = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] c_lock_cnt   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] c_unlock_cnt = CNT_W'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] c_idle_bits  = CNT_W'(IDLE_BITS);

  logic             r_s1, r_s2, r_s3, r_hs_q;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_good_cnt, w_good_nxt;
  logic [CNT_W-1:0] r_bad_cnt, w_bad_nxt;
  logic [CNT_W-1:0] r_idle_cnt, w_idle_nxt;
  logic [CNT_W-1:0] r_phase_err, w_err_nxt;
  logic             r_rclk, r_data, w_data_nxt, r_valid, w_valid_nxt, r_lost, w_lost_nxt;

  logic [CNT_W-1:0] w_osr, w_sp, w_phase_inc, w_phase_adv, w_err, w_err_mag;
  logic [CNT_W-1:0] w_good_inc, w_bad_inc, w_idle_inc;
  logic [CNT_W:0]   w_phase_p2;
  logic             w_edge, w_clear, w_wrap, w_late, w_good_edge;

  assign w_osr       = i_hs_mode ? c_osr_hs : c_osr_fs;
  assign w_sp        = w_osr >> 1;
  assign w_edge      = r_s2 ^ r_s3;
  // Mode change and disable share one clear path; it overrides any edge this cycle.
  assign w_clear     = !i_enable || (i_hs_mode != r_hs_q);
  assign w_wrap      = (r_phase == w_osr - c_one);
  assign w_phase_inc = w_wrap ? '0 : r_phase + c_one;
  assign w_phase_p2  = {1'b0, r_phase} + c_two;
  assign w_phase_adv = (w_phase_p2 >= {1'b0, w_osr}) ? CNT_W'(w_phase_p2 - {1'b0, w_osr})
                                                     : w_phase_p2[CNT_W-1:0];
  assign w_late      = (r_phase < w_sp);
  assign w_err       = w_late ? r_phase : r_phase - w_osr;
  assign w_err_mag   = w_late ? r_phase : w_osr - r_phase;
  assign w_good_edge = (w_err_mag <= c_tol);
  assign w_good_inc  = (r_good_cnt == c_cnt_max) ? c_cnt_max : r_good_cnt + c_one;
  assign w_bad_inc   = (r_bad_cnt  == c_cnt_max) ? c_cnt_max : r_bad_cnt  + c_one;
  assign w_idle_inc  = (r_idle_cnt == c_cnt_max) ? c_cnt_max : r_idle_cnt + c_one;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = w_phase_inc;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    w_idle_nxt  = r_idle_cnt;
    w_err_nxt   = r_phase_err;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_lost_nxt  = 1'b0;
    if (w_clear) begin
      w_phase_nxt = '0;
      w_state_nxt = ST_UNLOCKED;
      w_good_nxt  = '0;
      w_bad_nxt   = '0;
      w_idle_nxt  = '0;
      w_lost_nxt  = (r_state == ST_LOCKED);
    end else begin
      if (r_phase == w_sp) begin
        w_data_nxt  = r_s2;
        w_valid_nxt = (r_state == ST_LOCKED);
      end
      if (w_edge) begin
        w_err_nxt  = w_err;
        w_idle_nxt = '0;
        if (w_late && (r_phase != '0)) w_phase_nxt = r_phase;
        else if (!w_late)              w_phase_nxt = w_phase_adv;
      end
      case (r_state)
        ST_UNLOCKED: begin
          if (w_edge) begin
            w_state_nxt = ST_ACQUIRE;
            w_good_nxt  = '0;
          end
        end
        ST_ACQUIRE: begin
          if (w_edge) begin
            if (!w_good_edge) begin
              w_good_nxt = '0;
            end else if (w_good_inc >= c_lock_cnt) begin
              w_state_nxt = ST_LOCKED;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end else begin
              w_good_nxt = w_good_inc;
            end
          end
        end
        ST_LOCKED: begin
          if (w_edge) begin
            if (w_good_edge) begin
              w_bad_nxt = '0;
            end else if (w_bad_inc >= c_unlock_cnt) begin
              w_state_nxt = ST_UNLOCKED;
              w_lost_nxt  = 1'b1;
              w_bad_nxt   = '0;
            end else begin
              w_bad_nxt = w_bad_inc;
            end
          end else if (w_wrap) begin
            if (w_idle_inc >= c_idle_bits) begin
              w_state_nxt = ST_UNLOCKED;
              w_lost_nxt  = 1'b1;
              w_idle_nxt  = '0;
            end else begin
              w_idle_nxt = w_idle_inc;
            end
          end
        end
        default: w_state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge i_clk_ref or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_hs_q      <= 1'b0;
      r_state     <= ST_UNLOCKED;
      r_phase     <= '0;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_idle_cnt  <= '0;
      r_phase_err <= '0;
      r_rclk      <= 1'b0;
      r_data      <= 1'b0;
      r_valid     <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_s1        <= i_data;
      r_s2        <= r_s1;
      r_s3        <= r_s2;
      r_hs_q      <= i_hs_mode;
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_good_cnt  <= w_good_nxt;
      r_bad_cnt   <= w_bad_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_phase_err <= w_err_nxt;
      r_rclk      <= (w_phase_nxt < w_sp);
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_lost      <= w_lost_nxt;
    end
  end

  assign o_recovered_clk = r_rclk;
  assign o_data          = r_data;
  assign o_data_valid    = r_valid;
  assign o_lock_detect   = (r_state == ST_LOCKED);
  assign o_lock_lost     = r_lost;
  assign o_phase_err     = r_phase_err;
  assign o_state         = r_state;

endmodule
`default_nettype wire
